// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rsa_pkg
// Purpose  : Shared types and constants for the RSA exponentiation controller
//            and the Montgomery multiplier environment.
// Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  // Default operand width of the RSA datapath
  localparam int RSA_WIDTH = 8;

  // Multiplicative identity in the plain domain (used for 1*R conversions)
  localparam logic [RSA_WIDTH-1:0] ONE = RSA_WIDTH'(1);

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TO_M   = 3'd1,
    ST_TO_ONE = 3'd2,
    ST_SQR    = 3'd3,
    ST_MUL    = 3'd4,
    ST_FROM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ABORT  = 3'd7
  } rsa_ctrl_state_t;

  // Sources that can be routed onto an MMM operand port
  typedef enum logic [2:0] {
    SEL_M     = 3'd0,
    SEL_CONST = 3'd1,
    SEL_ONE   = 3'd2,
    SEL_X     = 3'd3,
    SEL_MBAR  = 3'd4
  } rsa_op_sel_t;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_exp_ctrl
// Purpose  : Square-and-multiply sequencer computing c = m^e mod p through an
//            external Montgomery multiplier driven by a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic             mmm_start,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_p,
  input  logic             mmm_done,
  input  logic [WIDTH-1:0] mmm_result,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy,
  output logic             err
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(ONE);
  localparam logic [BIT_W-1:0] C_TOPIX = BIT_W'(WIDTH - 1);

  rsa_ctrl_state_t  r_state;
  logic             r_mmm_start;
  logic [WIDTH-1:0] r_a, r_b, r_p, r_e, r_const;
  logic [WIDTH-1:0] r_mbar, r_xbar, r_c;
  logic [BIT_W-1:0] r_idx;
  logic             r_eoc, r_err;

  rsa_ctrl_state_t  w_nxt;
  logic             w_launch, w_dec, w_accept, w_op, w_take;
  rsa_op_sel_t      w_sel_a, w_sel_b;
  logic [WIDTH-1:0] w_const, w_opa, w_opb;

  // Route one operand source; new x_bar comes straight from the finishing multiply
  function automatic logic [WIDTH-1:0] f_pick(input rsa_op_sel_t s,
                                              input logic [WIDTH-1:0] m,
                                              input logic [WIDTH-1:0] cst,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] mbar);
    case (s)
      SEL_M:     f_pick = m;
      SEL_CONST: f_pick = cst;
      SEL_X:     f_pick = x;
      SEL_MBAR:  f_pick = mbar;
      default:   f_pick = C_ONE;
    endcase
  endfunction

  assign w_op     = (r_state == ST_TO_M) || (r_state == ST_TO_ONE) || (r_state == ST_SQR) ||
                    (r_state == ST_MUL)  || (r_state == ST_FROM);
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start_cmd;
  // A result is committed only when the run is not being aborted on that cycle
  assign w_take   = w_op && mmm_done && !stop_cmd;
  assign w_const  = w_accept ? rsa_const : r_const;

  // Next-state, launch and bit-index decrement decisions
  always_comb begin
    w_nxt    = r_state;
    w_launch = 1'b0;
    w_dec    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_cmd) begin
          if (!rsa_p[0]) begin
            w_nxt = ST_DONE;
          end else begin
            w_nxt    = ST_TO_M;
            w_launch = 1'b1;
          end
        end
      end
      ST_TO_M, ST_TO_ONE, ST_SQR, ST_MUL, ST_FROM: begin
        if (mmm_done) begin
          if (stop_cmd) begin
            // Multiply already finished: nothing left to drain
            w_nxt = ST_IDLE;
          end else begin
            case (r_state)
              ST_TO_M:   begin w_nxt = ST_TO_ONE; w_launch = 1'b1; end
              ST_TO_ONE: begin w_nxt = ST_SQR;    w_launch = 1'b1; end
              ST_SQR: begin
                w_launch = 1'b1;
                if (r_e[r_idx])        w_nxt = ST_MUL;
                else if (r_idx == '0)  w_nxt = ST_FROM;
                else begin             w_nxt = ST_SQR; w_dec = 1'b1; end
              end
              ST_MUL: begin
                w_launch = 1'b1;
                if (r_idx == '0) w_nxt = ST_FROM;
                else begin       w_nxt = ST_SQR; w_dec = 1'b1; end
              end
              default: w_nxt = ST_DONE;
            endcase
          end
        end else if (stop_cmd) begin
          w_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (mmm_done) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Operand selection for the multiply being launched into w_nxt
  always_comb begin
    w_sel_a = SEL_ONE;
    w_sel_b = SEL_ONE;
    case (w_nxt)
      ST_TO_M:   begin w_sel_a = SEL_M;   w_sel_b = SEL_CONST; end
      ST_TO_ONE: begin w_sel_a = SEL_ONE; w_sel_b = SEL_CONST; end
      ST_SQR:    begin w_sel_a = SEL_X;   w_sel_b = SEL_X;     end
      ST_MUL:    begin w_sel_a = SEL_X;   w_sel_b = SEL_MBAR;  end
      ST_FROM:   begin w_sel_a = SEL_X;   w_sel_b = SEL_ONE;   end
      default:   begin w_sel_a = SEL_ONE; w_sel_b = SEL_ONE;   end
    endcase
  end

  assign w_opa = f_pick(w_sel_a, rsa_m, w_const, mmm_result, r_mbar);
  assign w_opb = f_pick(w_sel_b, rsa_m, w_const, mmm_result, r_mbar);

  // Controller state, operand registers and result capture, all gated by ena
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_mmm_start <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_e         <= '0;
      r_const     <= '0;
      r_mbar      <= '0;
      r_xbar      <= '0;
      r_c         <= '0;
      r_idx       <= '0;
      r_eoc       <= 1'b0;
      r_err       <= 1'b0;
    end else if (ena) begin
      r_state     <= w_nxt;
      r_mmm_start <= w_launch;
      if (w_launch) begin
        r_a <= w_opa;
        r_b <= w_opb;
      end
      if (w_dec) r_idx <= r_idx - 1'b1;
      if (w_accept) begin
        r_p     <= rsa_p;
        r_e     <= rsa_e;
        r_const <= rsa_const;
        r_idx   <= C_TOPIX;
        r_eoc   <= 1'b0;
        r_err   <= 1'b0;
        if (!rsa_p[0]) begin
          // Even modulus has no Montgomery inverse: reject with a zero result
          r_c   <= '0;
          r_eoc <= 1'b1;
          r_err <= 1'b1;
        end
      end
      if (w_take) begin
        case (r_state)
          ST_TO_M:              r_mbar <= mmm_result;
          ST_TO_ONE, ST_SQR,
          ST_MUL:               r_xbar <= mmm_result;
          default: begin
            r_c   <= mmm_result;
            r_eoc <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mmm_start = r_mmm_start;
  assign mmm_a     = r_a;
  assign mmm_b     = r_b;
  assign mmm_p     = r_p;
  assign rsa_c     = r_c;
  assign eoc       = r_eoc;
  assign err       = r_err;
  assign busy      = !((r_state == ST_IDLE) || (r_state == ST_DONE));

endmodule : rsa_exp_ctrl
`default_nettype wire

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
Sequencing controller for the RSA modular-exponentiation datapath; computes c = m^e mod p by square-and-multiply over a Montgomery multiplier (MMM).
Sits between the SPI register bank (start/stop commands, operands P/E/M/Const) and the MMM. Returns rsa_c and a level eoc for status polling and capture into the C register.
The MMM is an external instance driven through a start/done handshake; this block owns operand selection, bit iteration, abort and error handling.

Parameters:
WIDTH, 8, operand width of p, e, m, const, c and MMM operands/result
BIT_W, $clog2(WIDTH), width of exponent bit index (localparam)

Ports:
clk  in  1  clock
rstb  in  1  reset, asynchronous, active-low
ena  in  1  global enable; when low all state holds, no outputs change
start_cmd  in  1  one-cycle start pulse
stop_cmd  in  1  one-cycle abort pulse
rsa_p  in  WIDTH  modulus, must be odd
rsa_e  in  WIDTH  exponent
rsa_m  in  WIDTH  message, software guarantees m < p
rsa_const  in  WIDTH  R^2 mod p, R = 2^WIDTH
mmm_start  out  1  one-cycle pulse launching one Montgomery multiply
mmm_a  out  WIDTH  MMM operand A, held stable from mmm_start to mmm_done
mmm_b  out  WIDTH  MMM operand B, held stable from mmm_start to mmm_done
mmm_p  out  WIDTH  latched modulus to MMM
mmm_done  in  1  one-cycle pulse, mmm_result valid same cycle (MMM shares ena)
mmm_result  in  WIDTH  a*b*R^-1 mod p
rsa_c  out  WIDTH  result register
eoc  out  1  level: result valid
busy  out  1  high in any state except IDLE/DONE
err  out  1  level: last start rejected (even p)

Behaviour:
- Reset: state IDLE; rsa_c=0, eoc=0, busy=0, err=0, mmm_start=0, mmm_a=mmm_b=mmm_p=0; internal m_bar, x_bar, e_q, bit index cleared.
- All register updates are qualified by ena. With ena low, the FSM freezes and an in-flight multiply is also frozen, because the MMM uses the same ena.
- States: IDLE, TO_M, TO_ONE, SQR, MUL, FROM, DONE, ABORT.
- IDLE/DONE + start_cmd:
  - Latch p, e, m, const; clear eoc and err.
  - If p[0]==0: go to DONE with rsa_c=0, eoc=1, err=1. Issue no mmm_start.
  - Else: go to TO_M, bit index = WIDTH-1.
- Each op state issues mmm_start on its first cycle, then waits for mmm_done. The transition occurs on the done cycle. mmm_start is never issued while a multiply is outstanding.
- TO_M: a=m, b=const; result -> m_bar; next TO_ONE.
- TO_ONE: a=1, b=const; result -> x_bar (= R mod p); next SQR.
- SQR: a=b=x_bar; result -> x_bar.
  - If e_q[idx]=1: next MUL.
  - Else if idx==0: next FROM.
  - Else: idx-1, next SQR.
- MUL: a=x_bar, b=m_bar; result -> x_bar.
  - If idx==0: next FROM.
  - Else: idx-1, next SQR.
- FROM: a=x_bar, b=1; result -> rsa_c; eoc=1 (registered, visible the cycle after done); next DONE.
- DONE: eoc held high until the next accepted start_cmd; rsa_c held.
- Multiply count: 2 + WIDTH + popcount(e) + 1. No leading-zero skipping.
- e=0 produces c=1, valid for p>=3.
- stop_cmd:
  - In a waiting op state: go to ABORT; consume the outstanding mmm_done, then go to IDLE.
  - On the cycle a multiply is being launched: mmm_start still fires, then go to ABORT.
  - In IDLE/DONE: no effect.
  - Abort leaves rsa_c unchanged and eoc=0.
- start_cmd in any busy state or ABORT is ignored.
- Simultaneous start_cmd and stop_cmd in IDLE/DONE: start wins. In busy states: stop wins.
- Operand inputs are sampled only at accepted start; later changes do not affect a run.
- Async reset mid-operation returns to reset values immediately; the MMM is reset by the same rstb.

Decomposition:
- Shared package rsa_pkg:
  - state enum (typedef rsa_ctrl_state_t)
  - localparam ONE = WIDTH'(1)
  - operand-select enum (SEL_M, SEL_CONST, SEL_ONE, SEL_X, SEL_MBAR), reused by the MMM bench.
- No sub-module needed: the operand mux and bit counter are inline. The MMM (rsa_mmm) stays a separate existing-style instance at the level above.

Test Plan:
(All scenarios use WIDTH=8 and a behavioural MMM returning a*b*R^-1 mod p, R=256, with a 4-cycle latency.)
- p=13, const=3, m=4, e=5, start -> exactly 13 mmm_start pulses, rsa_c=10, eoc=1, busy=0, err=0.
- p=13, const=3, m=7, e=0 -> 11 multiplies, rsa_c=1, eoc=1.
- p=12, start -> no mmm_start, rsa_c=0, eoc=1, err=1 the cycle after start.
- Run p=13, e=5 to completion (rsa_c=10); restart with e=255; stop_cmd during SQR -> ABORT until mmm_done, then IDLE; rsa_c stays 10, eoc=0; next start is accepted normally.
- start_cmd pulsed mid-run and operand inputs changed mid-run -> result still 10 for the original operands; stop and start in the same cycle while busy -> abort.
- ena held low 20 cycles mid-run (MMM also stalled) -> same result 10; cycle count extended by exactly 20.
